// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C write-only target: FSM encodings, default
// address and the address-phase decode helper.
package i2c_pkg;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_ADDR     = 4'd1,
    ST_ACK_ADDR = 4'd2,
    ST_DATA     = 4'd3,
    ST_ACK_DATA = 4'd4,
    ST_IGNORE   = 4'd5
  } state_t;

  localparam logic [6:0] DEFAULT_SLAVE_ADDR = 7'h50;

  // True when the address byte selects this target for a write.
  function automatic logic is_write_to(input logic [7:0] addr_byte, input logic [6:0] addr);
    return (addr_byte[7:1] == addr) && (addr_byte[0] == 1'b0);
  endfunction

endpackage

// File: rtl/i2c_sync_edge.sv
// Two-flop synchronizer with one history stage; emits the synchronized level
// and single-clk rise/fall pulses. Resets to the idle-bus level (high).
module i2c_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic meta_r;
  logic sync_r;
  logic hist_r;

  // Synchronizer chain plus history register for edge detection.
  always_ff @(posedge clk) begin
    if (!reset) begin
      meta_r <= 1'b1;
      sync_r <= 1'b1;
      hist_r <= 1'b1;
    end else begin
      meta_r <= din;
      sync_r <= meta_r;
      hist_r <= sync_r;
    end
  end

  assign level = sync_r;
  assign rise  = sync_r & ~hist_r;
  assign fall  = ~sync_r & hist_r;

endmodule

// File: rtl/i2c_slave.sv
// I2C write-only target: receives address + data bytes, ACKs its own address
// and every data byte, and flags each received byte with a one-clk pulse.
module i2c_slave
  import i2c_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR = DEFAULT_SLAVE_ADDR
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl,
  input  logic       sda_in,
  output logic       sda_out,
  output logic       sda_oe,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       addr_match,
  output logic [3:0] state
);

  logic   scl_level, scl_rise, scl_fall;
  logic   sda_level, sda_rise, sda_fall;
  logic   scl_steady_s, start_s, stop_s;
  state_t state_r;
  logic [2:0] bit_cnt_r;
  logic [7:0] shift_r;
  logic       byte_full_r;

  i2c_sync_edge u_scl_sync (
    .clk   (clk),
    .reset (reset),
    .din   (scl),
    .level (scl_level),
    .rise  (scl_rise),
    .fall  (scl_fall)
  );

  i2c_sync_edge u_sda_sync (
    .clk   (clk),
    .reset (reset),
    .din   (sda_in),
    .level (sda_level),
    .rise  (sda_rise),
    .fall  (sda_fall)
  );

  // SCL high now and in the previous sample (level without a fresh rise).
  assign scl_steady_s = scl_level & ~scl_rise;
  assign start_s      = sda_fall & scl_steady_s;
  assign stop_s       = sda_rise & scl_steady_s;
  assign state        = state_r;

  // Protocol FSM; bus conditions override any byte in progress.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r     <= ST_IDLE;
      sda_oe      <= 1'b0;
      sda_out     <= 1'b1;
      data_out    <= 8'd0;
      data_valid  <= 1'b0;
      addr_match  <= 1'b0;
      bit_cnt_r   <= 3'd0;
      shift_r     <= 8'd0;
      byte_full_r <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      if (stop_s) begin
        state_r     <= ST_IDLE;
        sda_oe      <= 1'b0;
        sda_out     <= 1'b1;
        addr_match  <= 1'b0;
        byte_full_r <= 1'b0;
      end else if (start_s) begin
        state_r     <= ST_ADDR;
        sda_oe      <= 1'b0;
        sda_out     <= 1'b1;
        addr_match  <= 1'b0;
        bit_cnt_r   <= 3'd7;
        shift_r     <= 8'd0;
        byte_full_r <= 1'b0;
      end else begin
        case (state_r)
          ST_IDLE: begin
          end
          ST_ADDR, ST_DATA: begin
            if (scl_rise && !byte_full_r) begin
              shift_r <= {shift_r[6:0], sda_level};
              if (bit_cnt_r == 3'd0) begin
                byte_full_r <= 1'b1;
              end else begin
                bit_cnt_r <= bit_cnt_r - 3'd1;
              end
            end else if (scl_fall && byte_full_r) begin
              byte_full_r <= 1'b0;
              if (state_r == ST_ADDR) begin
                if (is_write_to(shift_r, SLAVE_ADDR)) begin
                  sda_oe     <= 1'b1;
                  sda_out    <= 1'b0;
                  addr_match <= 1'b1;
                  state_r    <= ST_ACK_ADDR;
                end else begin
                  state_r <= ST_IGNORE;
                end
              end else begin
                data_out   <= shift_r;
                data_valid <= 1'b1;
                sda_oe     <= 1'b1;
                sda_out    <= 1'b0;
                state_r    <= ST_ACK_DATA;
              end
            end
          end
          ST_ACK_ADDR, ST_ACK_DATA: begin
            if (scl_fall) begin
              sda_oe    <= 1'b0;
              sda_out   <= 1'b1;
              bit_cnt_r <= 3'd7;
              state_r   <= ST_DATA;
            end
          end
          ST_IGNORE: begin
          end
          default: begin
            state_r    <= ST_IDLE;
            sda_oe     <= 1'b0;
            sda_out    <= 1'b1;
            addr_match <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_slave.sv
// Directed bench for i2c_slave: a bit-banged bus master with a wired-AND SDA
// line and a negedge monitor that records every data_valid pulse.
module tb_i2c_slave;

  logic       clk = 1'b0;
  logic       reset;
  logic       scl_m;
  logic       sda_m;
  logic       sda_bus;
  logic       sda_out, sda_oe, data_valid, addr_match;
  logic [7:0] data_out;
  logic [3:0] state;

  int         n_assert = 0;
  int         n_fail   = 0;
  int         dv_cnt   = 0;
  logic       oe_seen  = 1'b0;
  logic [7:0] dv_q[$];
  logic       ack;
  int         ack_cnt;

  always #5 clk = ~clk;

  assign sda_bus = sda_m & (sda_oe ? sda_out : 1'b1);

  i2c_slave #(.SLAVE_ADDR(7'h50)) dut (
    .clk        (clk),
    .reset      (reset),
    .scl        (scl_m),
    .sda_in     (sda_bus),
    .sda_out    (sda_out),
    .sda_oe     (sda_oe),
    .data_out   (data_out),
    .data_valid (data_valid),
    .addr_match (addr_match),
    .state      (state)
  );

  always @(negedge clk) begin
    if (data_valid) begin
      dv_cnt = dv_cnt + 1;
      dv_q.push_back(data_out);
    end
    if (sda_oe) oe_seen = 1'b1;
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic clear_mon();
    dv_cnt  = 0;
    oe_seen = 1'b0;
    dv_q.delete();
  endtask

  task automatic i2c_start();
    if (scl_m == 1'b0) begin
      wait_clk(2); sda_m = 1'b1;
      wait_clk(8); scl_m = 1'b1;
      wait_clk(10);
    end
    sda_m = 1'b0;
    wait_clk(10); scl_m = 1'b0;
  endtask

  task automatic i2c_stop();
    wait_clk(2);  sda_m = 1'b0;
    wait_clk(8);  scl_m = 1'b1;
    wait_clk(10); sda_m = 1'b1;
    wait_clk(10);
  endtask

  task automatic send_bit(input logic b);
    wait_clk(2);  sda_m = b;
    wait_clk(8);  scl_m = 1'b1;
    wait_clk(10); scl_m = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, output logic acked);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    wait_clk(2); sda_m = 1'b1;
    wait_clk(8); scl_m = 1'b1;
    wait_clk(5); acked = ~sda_bus;
    wait_clk(5); scl_m = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    scl_m = 1'b1;
    sda_m = 1'b1;
    wait_clk(3);
    check("rst_state", {4'd0, state}, 8'd0);
    check("rst_sda_oe", {7'd0, sda_oe}, 8'd0);
    check("rst_sda_out", {7'd0, sda_out}, 8'd1);
    check("rst_data_out", data_out, 8'h00);
    check("rst_data_valid", {7'd0, data_valid}, 8'd0);
    check("rst_addr_match", {7'd0, addr_match}, 8'd0);
    reset = 1'b1;
    wait_clk(5);

    // Single-byte write to our address
    clear_mon();
    i2c_start();
    send_byte(8'hA0, ack);
    check("w1_addr_ack", {7'd0, ack}, 8'd1);
    check("w1_addr_match", {7'd0, addr_match}, 8'd1);
    wait_clk(4);
    check("w1_state_data", {4'd0, state}, 8'd3);
    send_byte(8'hA5, ack);
    check("w1_data_ack", {7'd0, ack}, 8'd1);
    i2c_stop();
    check("w1_data_out", data_out, 8'hA5);
    check("w1_dv_cnt", dv_cnt[7:0], 8'd1);
    check("w1_state_idle", {4'd0, state}, 8'd0);
    check("w1_match_clr", {7'd0, addr_match}, 8'd0);

    // Foreign address: no drive, no data
    clear_mon();
    i2c_start();
    send_byte(8'hA2, ack);
    check("w2_addr_nack", {7'd0, ack}, 8'd0);
    send_byte(8'h3C, ack);
    check("w2_data_nack", {7'd0, ack}, 8'd0);
    check("w2_state_ignore", {4'd0, state}, 8'd5);
    i2c_stop();
    check("w2_oe_seen", {7'd0, oe_seen}, 8'd0);
    check("w2_dv_cnt", dv_cnt[7:0], 8'd0);
    check("w2_addr_match", {7'd0, addr_match}, 8'd0);

    // Multi-byte write
    clear_mon();
    ack_cnt = 0;
    i2c_start();
    send_byte(8'hA0, ack); ack_cnt += int'(ack);
    send_byte(8'h11, ack); ack_cnt += int'(ack);
    send_byte(8'h22, ack); ack_cnt += int'(ack);
    send_byte(8'h33, ack); ack_cnt += int'(ack);
    i2c_stop();
    check("w3_ack_cnt", ack_cnt[7:0], 8'd4);
    check("w3_dv_cnt", dv_cnt[7:0], 8'd3);
    check("w3_byte0", dv_q[0], 8'h11);
    check("w3_byte1", dv_q[1], 8'h22);
    check("w3_byte2", dv_q[2], 8'h33);

    // Read request is refused
    clear_mon();
    i2c_start();
    send_byte(8'hA1, ack);
    check("w4_nack", {7'd0, ack}, 8'd0);
    wait_clk(4);
    check("w4_state_ignore", {4'd0, state}, 8'd5);
    i2c_stop();
    check("w4_state_idle", {4'd0, state}, 8'd0);
    check("w4_oe_seen", {7'd0, oe_seen}, 8'd0);

    // Partial byte aborted by repeated START
    clear_mon();
    i2c_start();
    send_byte(8'hA0, ack);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    i2c_start();
    wait_clk(4);
    check("w5_state_addr", {4'd0, state}, 8'd1);
    check("w5_match_clr", {7'd0, addr_match}, 8'd0);
    send_byte(8'hA0, ack);
    check("w5_addr_ack", {7'd0, ack}, 8'd1);
    send_byte(8'h7E, ack);
    i2c_stop();
    check("w5_dv_cnt", dv_cnt[7:0], 8'd1);
    check("w5_byte", dv_q[0], 8'h7E);
    check("w5_data_out", data_out, 8'h7E);

    // Reset during the data ACK low phase
    clear_mon();
    i2c_start();
    send_byte(8'hA0, ack);
    for (int i = 7; i >= 0; i--) send_bit(1'(8'h55 >> i));
    wait_clk(5);
    check("w6_ack_driven", {7'd0, sda_oe}, 8'd1);
    reset = 1'b0;
    wait_clk(1);
    check("w6_oe_released", {7'd0, sda_oe}, 8'd0);
    check("w6_rst_state", {4'd0, state}, 8'd0);
    check("w6_rst_data_out", data_out, 8'h00);
    wait_clk(1);
    reset = 1'b1;
    wait_clk(3);
    clear_mon();
    i2c_start();
    send_byte(8'hA0, ack);
    check("w6_addr_ack", {7'd0, ack}, 8'd1);
    send_byte(8'h99, ack);
    check("w6_data_ack", {7'd0, ack}, 8'd1);
    i2c_stop();
    check("w6_dv_cnt", dv_cnt[7:0], 8'd1);
    check("w6_data_out", data_out, 8'h99);
    check("w6_state_idle", {4'd0, state}, 8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
